// File: rtl/debouncer_if.sv
// Bundles the per-channel debouncer signals: noisy inputs in, qualified levels and busy flags out.
// The master drives raw; the debouncer (slave) drives clean and busy.
interface debouncer_if #(
    parameter int N = 2
);
    logic [N-1:0] raw;
    logic [N-1:0] clean;
    logic [N-1:0] busy;

    modport master (output raw, input clean, input busy);
    modport slave  (input raw, output clean, output busy);
endinterface

// File: rtl/debouncer.sv
// N-channel switch debouncer: 2-flop synchronizer, then a per-channel FSM that only moves
// clean after STABLE_CYCLES consecutive observations of the opposite level.
module debouncer #(
    parameter int N             = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rst,
    debouncer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_STABLE_LOW,
        ST_WAIT_HIGH,
        ST_STABLE_HIGH,
        ST_WAIT_LOW
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    for (genvar gi = 0; gi < N; gi++) begin : g_ch
        logic             r_sync1;
        logic             r_sync2;
        state_t           r_state;
        state_t           w_state_next;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic             r_clean;
        logic             w_clean_next;
        logic             r_busy;
        logic             w_busy_next;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
            end else begin
                r_sync1 <= bus.raw[gi];
                r_sync2 <= r_sync1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state <= ST_STABLE_LOW;
                r_cnt   <= '0;
                r_clean <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                r_state <= w_state_next;
                r_cnt   <= w_cnt_next;
                r_clean <= w_clean_next;
                r_busy  <= w_busy_next;
            end
        end

        // The counter is zero everywhere except while a candidate level is being qualified.
        always_comb begin
            w_state_next = r_state;
            w_cnt_next   = '0;
            case (r_state)
                ST_STABLE_LOW: begin
                    if (r_sync2) begin
                        if (STABLE_CYCLES == 1) begin
                            w_state_next = ST_STABLE_HIGH;
                        end else begin
                            w_state_next = ST_WAIT_HIGH;
                            w_cnt_next   = ONE_CNT;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (!r_sync2) begin
                        w_state_next = ST_STABLE_LOW;
                    end else if (r_cnt == LAST_CNT) begin
                        w_state_next = ST_STABLE_HIGH;
                    end else begin
                        w_cnt_next = r_cnt + ONE_CNT;
                    end
                end
                ST_STABLE_HIGH: begin
                    if (!r_sync2) begin
                        if (STABLE_CYCLES == 1) begin
                            w_state_next = ST_STABLE_LOW;
                        end else begin
                            w_state_next = ST_WAIT_LOW;
                            w_cnt_next   = ONE_CNT;
                        end
                    end
                end
                ST_WAIT_LOW: begin
                    if (r_sync2) begin
                        w_state_next = ST_STABLE_HIGH;
                    end else if (r_cnt == LAST_CNT) begin
                        w_state_next = ST_STABLE_LOW;
                    end else begin
                        w_cnt_next = r_cnt + ONE_CNT;
                    end
                end
                default: begin
                    w_state_next = ST_STABLE_LOW;
                end
            endcase

            w_clean_next = (w_state_next == ST_STABLE_HIGH) || (w_state_next == ST_WAIT_LOW);
            w_busy_next  = (w_state_next == ST_WAIT_HIGH)   || (w_state_next == ST_WAIT_LOW);
        end

        assign bus.clean[gi] = r_clean;
        assign bus.busy[gi]  = r_busy;
    end

endmodule

// File: tb/tb_debouncer.sv
// Directed bench for the 2-channel debouncer (STABLE_CYCLES=4): stimulus queues the expected
// clean/busy for each edge, a monitor compares after that edge.
module tb_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    typedef struct {
        int         cyc;
        logic [1:0] clean;
        logic [1:0] busy;
        string      name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    logic       det_en = 1'b0;
    logic [1:0] det_prev = 2'b00;
    int         pulses0 = 0;
    int         pulses1 = 0;

    debouncer_if #(.N(2)) intf ();

    debouncer #(
        .N            (2),
        .STABLE_CYCLES(4),
        .CNT_W        (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(intf.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (edge %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Drive raw at a falling edge, queue what the next rising edge must produce.
    task automatic step(input logic [1:0] r, input logic [1:0] c, input logic [1:0] b,
                        input string nm);
        exp_t e;
        intf.raw = r;
        e.cyc    = cyc + 1;
        e.clean  = c;
        e.busy   = b;
        e.name   = nm;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic hold(input logic [1:0] r, input logic [1:0] c, input logic [1:0] b,
                        input int n, input string nm);
        for (int k = 0; k < n; k++) step(r, c, b, nm);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                mon_e = sb_q.pop_front();
                if (mon_e.cyc < cyc) begin
                    chk({mon_e.name, "_missed"}, 32'(mon_e.cyc), 32'(cyc));
                end else begin
                    $display("[MON] edge %0d %s clean=%b busy=%b", cyc, mon_e.name,
                             intf.clean, intf.busy);
                    chk({mon_e.name, "_clean"}, 32'(intf.clean), 32'(mon_e.clean));
                    chk({mon_e.name, "_busy"},  32'(intf.busy),  32'(mon_e.busy));
                end
            end
        end
    end

    // Downstream rising-edge detector fed by clean.
    always @(negedge clk) begin
        det_prev <= intf.clean;
        if (det_en) begin
            if (intf.clean[0] && !det_prev[0]) pulses0 <= pulses0 + 1;
            if (intf.clean[1] && !det_prev[1]) pulses1 <= pulses1 + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        intf.raw = 2'b00;
        #1;
        rst = 1'b1;
        #1;
        chk("reset_async_clean", 32'(intf.clean), 32'd0);
        chk("reset_async_busy",  32'(intf.busy),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        hold(2'b00, 2'b00, 2'b00, 10, "idle");

        hold(2'b01, 2'b00, 2'b00, 2, "rise0");
        hold(2'b01, 2'b00, 2'b01, 3, "rise0");
        hold(2'b01, 2'b01, 2'b00, 3, "rise0");
        hold(2'b00, 2'b01, 2'b00, 2, "fall0");
        hold(2'b00, 2'b01, 2'b01, 3, "fall0");
        hold(2'b00, 2'b00, 2'b00, 3, "fall0");

        hold(2'b01, 2'b00, 2'b00, 2, "glitch3");
        hold(2'b01, 2'b00, 2'b01, 1, "glitch3");
        hold(2'b00, 2'b00, 2'b01, 2, "glitch3");
        hold(2'b00, 2'b00, 2'b00, 3, "glitch3");

        hold(2'b01, 2'b00, 2'b00, 2, "pulse4");
        hold(2'b01, 2'b00, 2'b01, 2, "pulse4");
        hold(2'b00, 2'b00, 2'b01, 1, "pulse4");
        hold(2'b00, 2'b01, 2'b00, 1, "pulse4");
        hold(2'b00, 2'b01, 2'b01, 3, "pulse4");
        hold(2'b00, 2'b00, 2'b00, 2, "pulse4");

        hold(2'b01, 2'b00, 2'b00, 2, "par_rise");
        hold(2'b11, 2'b00, 2'b01, 2, "par_rise");
        hold(2'b11, 2'b00, 2'b11, 1, "par_rise");
        hold(2'b11, 2'b01, 2'b10, 2, "par_rise");
        hold(2'b11, 2'b11, 2'b00, 2, "par_rise");
        hold(2'b10, 2'b11, 2'b00, 2, "par_fall0");
        hold(2'b10, 2'b11, 2'b01, 3, "par_fall0");
        hold(2'b10, 2'b10, 2'b00, 2, "par_fall0");
        hold(2'b00, 2'b10, 2'b00, 2, "par_fall1");
        hold(2'b00, 2'b10, 2'b10, 3, "par_fall1");
        hold(2'b00, 2'b00, 2'b00, 2, "par_fall1");

        hold(2'b01, 2'b00, 2'b00, 2, "midrst");
        hold(2'b01, 2'b00, 2'b01, 1, "midrst");
        rst = 1'b1;
        #1;
        chk("midrst_async_clean", 32'(intf.clean), 32'd0);
        chk("midrst_async_busy",  32'(intf.busy),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        hold(2'b01, 2'b00, 2'b00, 2, "after_rst");
        hold(2'b01, 2'b00, 2'b01, 3, "after_rst");
        hold(2'b01, 2'b01, 2'b00, 2, "after_rst");
        hold(2'b00, 2'b01, 2'b00, 2, "after_rst");
        hold(2'b00, 2'b01, 2'b01, 3, "after_rst");
        hold(2'b00, 2'b00, 2'b00, 2, "after_rst");

        rst = 1'b1;
        intf.raw = 2'b11;
        @(negedge clk);
        det_en = 1'b1;
        rst = 1'b0;
        hold(2'b11, 2'b00, 2'b00, 2, "hi_release");
        hold(2'b11, 2'b00, 2'b11, 3, "hi_release");
        hold(2'b11, 2'b11, 2'b00, 6, "hi_release");
        @(negedge clk);
        chk("edge_pulses_ch0", 32'(pulses0), 32'd1);
        chk("edge_pulses_ch1", 32'(pulses1), 32'd1);

        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/debouncer.md
DEBOUNCER -- requirements
Module: debouncer

Interface
REQ-001 Parameter N, default 2: number of independent input channels.
REQ-002 Parameter STABLE_CYCLES, default 4: consecutive cycles an input must differ from clean before clean changes; legal range 1..65535.
REQ-003 Parameter CNT_W, default 16: counter width; SHALL be wide enough to hold STABLE_CYCLES.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 raw  input  N  asynchronous noisy inputs (buttons/switches).
REQ-007 clean  output  N  debounced level per channel, registered; feeds the downstream rising-edge detector input directly.
REQ-008 busy  output  N  per channel, high while a candidate change is being qualified.

Function
REQ-009 Each channel SHALL pass raw[i] through a 2-flop synchronizer (sync1 then sync2) before any other logic.
REQ-010 Each channel SHALL have an independent FSM with states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW and an independent CNT_W-bit counter.
REQ-011 clean[i] SHALL be 0 in STABLE_LOW and WAIT_HIGH, and 1 in STABLE_HIGH and WAIT_LOW.
REQ-012 busy[i] SHALL be 1 exactly in WAIT_HIGH and WAIT_LOW, registered with the state.
REQ-013 STABLE_LOW, sync2=1: STABLE_CYCLES=1 -> STABLE_HIGH; else -> WAIT_HIGH, count=1.
REQ-014 STABLE_HIGH, sync2=0: mirror of REQ-013 -> STABLE_LOW or WAIT_LOW, count=1.
REQ-015 WAIT_HIGH, sync2=1: count=STABLE_CYCLES-1 -> STABLE_HIGH, count=0; else count+1.
REQ-016 WAIT_HIGH, sync2=0: glitch rejected -> STABLE_LOW, count=0, clean unchanged.
REQ-017 WAIT_LOW: mirror of REQ-015/REQ-016 with inverted polarity.
REQ-018 Stable states with sync2 equal to clean: hold, count=0.
REQ-019 Latency: raw changes and holds, first sampled at edge 1; sync2 updates at edge 2; first FSM observation at edge 3; clean SHALL change at edge STABLE_CYCLES+2 (edge 6 at default).
REQ-020 Pulse held fewer than STABLE_CYCLES consecutive sync2 observations SHALL never change clean; every later qualification restarts from count=1.
REQ-021 Counter SHALL never exceed STABLE_CYCLES-1 and SHALL not wrap.
REQ-022 Channels SHALL be fully independent; simultaneous transitions on multiple channels qualify in parallel with no interaction.
REQ-023 clean SHALL change at most once per edge per channel and never glitch (register output, no combinational path from raw).

Reset
REQ-024 rst=1 SHALL immediately (no clock needed) force sync1=0, sync2=0, state=STABLE_LOW, count=0, clean=0, busy=0 on all channels.
REQ-025 rst asserted mid-WAIT SHALL abandon qualification; after release a full STABLE_CYCLES+2 edges are needed for any change.
REQ-026 raw held high through reset release SHALL produce clean=1 at edge STABLE_CYCLES+2 after release (one clean rising edge downstream).

Verification (STABLE_CYCLES=4, N=2)
REQ-027 Reset, raw=00 for 10 cycles -> clean=00, busy=00 throughout.
REQ-028 raw[0] 0->1 before edge 1, held -> busy[0]=1 after edges 3..5, clean[0]=1 at edge 6, busy[0]=0 at edge 6; clean[1]=0.
REQ-029 raw[0] high for exactly 3 cycles then low -> clean[0] stays 0, busy[0] returns 0; repeat with 4 cycles -> clean[0]=1.
REQ-030 raw[0] rises, raw[1] rises 2 cycles later -> clean[0] at edge 6, clean[1] at edge 8; then raw[0] falls -> clean[0]=0 four observations later, clean[1] stays 1.
REQ-031 raw[0] high, rst pulsed at edge 4 -> clean=00 and busy=00 asynchronously; after release clean[0]=1 at edge 6 relative to release.
REQ-032 raw=11 held across reset release, clean chained into the edge detector -> clean=11 at edge 6, exactly one detector=11 pulse, no further pulses.
